// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time IMEM loader: FSM state encoding,
// stream framing constants and small arithmetic helpers.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_LEN  = 3'd0,
    ST_DATA = 3'd1,
    ST_CHK  = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } state_e;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

  // Running checksum step: XOR of every byte seen so far.
  function automatic logic [7:0] xor_fold(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  // Byte address of word 'idx' above 'base'; wraps modulo 2^32.
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [15:0] idx);
    return base + {14'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream handshake, IMEM write port and status lines of the loader.
// 'slave' is the loader's view; 'master' is the surrounding system's view.
interface imem_loader_if;

  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_reset;
  logic        done;
  logic        error;

  modport slave (
    input  in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata, cpu_reset, done, error
  );

  modport master (
    output in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata, cpu_reset, done, error
  );

endinterface

// File: rtl/imem_loader_word_packer.sv
// Packs a byte stream into little-endian 32-bit words. The first byte of a
// word ends up in bits [7:0]. word_valid/word are combinational on the
// fourth byte so the caller can register the IMEM write in the same edge.
module word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  cnt_r;
  logic [23:0] sr_r;

  assign word_valid = byte_valid && (cnt_r == 2'(BYTES_PER_WORD - 1));
  assign word       = {byte_in, sr_r};

  // Byte counter and shift register; new bytes enter at the top.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= 2'd0;
      sr_r  <= 24'd0;
    end else if (byte_valid) begin
      cnt_r <= cnt_r + 2'd1;
      sr_r  <= {byte_in, sr_r[23:8]};
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: receives LEN_LO, LEN_HI, then 4*N data bytes, writes the
// packed words to IMEM from ADDR_BASE upward and releases cpu_reset once
// the image is complete.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds a trailing XOR
// checksum byte over the whole stream (header included).
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter int          MAX_WORDS = 1024
) (
  input logic         clk,
  input logic         reset,
  imem_loader_if.slave bus
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_e TAIL_ST = ST_CHK;
`else
  localparam state_e TAIL_ST = ST_DONE;
`endif

  state_e      state_r, next_state_s;
  logic        hdr_cnt_r;
  logic [7:0]  len_lo_r;
  logic [15:0] len_r;
  logic [15:0] index_r;
  logic        in_ready_r, imem_we_r, cpu_reset_r, done_r, error_r;
  logic [31:0] imem_addr_r, imem_wdata_r;

  logic        xfer_s, pack_valid_s, word_valid_s, last_word_s;
  logic [15:0] len_full_s;
  logic [31:0] word_s;

  assign xfer_s       = bus.in_valid && in_ready_r;
  assign pack_valid_s = xfer_s && (state_r == ST_DATA);
  assign len_full_s   = {bus.in_data, len_lo_r};
  assign last_word_s  = (index_r == (len_r - 16'd1));

  word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .byte_valid (pack_valid_s),
    .byte_in    (bus.in_data),
    .word_valid (word_valid_s),
    .word       (word_s)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] xor_r;

  // Running XOR over header and data bytes, compared in CHK.
  always_ff @(posedge clk) begin
    if (reset) begin
      xor_r <= 8'd0;
    end else if (xfer_s && ((state_r == ST_LEN) || (state_r == ST_DATA))) begin
      xor_r <= xor_fold(xor_r, bus.in_data);
    end
  end
`endif

  // Next-state decode for the load sequence.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_LEN: begin
        if (xfer_s && (hdr_cnt_r == 1'(HDR_BYTES - 1))) begin
          if ({1'b0, len_full_s} > 17'(MAX_WORDS)) begin
            next_state_s = ST_ERR;
          end else if (len_full_s == 16'd0) begin
            next_state_s = TAIL_ST;
          end else begin
            next_state_s = ST_DATA;
          end
        end else begin
          next_state_s = ST_LEN;
        end
      end
      ST_DATA: begin
        if (word_valid_s && last_word_s) begin
          next_state_s = TAIL_ST;
        end else begin
          next_state_s = ST_DATA;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CHK: begin
        if (xfer_s) begin
          next_state_s = (bus.in_data == xor_r) ? ST_DONE : ST_ERR;
        end else begin
          next_state_s = ST_CHK;
        end
      end
`endif
      ST_DONE: next_state_s = ST_DONE;
      ST_ERR:  next_state_s = ST_ERR;
      default: next_state_s = ST_ERR;
    endcase
  end

  // State register, header capture and word index.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_LEN;
      hdr_cnt_r <= 1'b0;
      len_lo_r  <= 8'd0;
      len_r     <= 16'd0;
      index_r   <= 16'd0;
    end else begin
      state_r <= next_state_s;
      if ((state_r == ST_LEN) && xfer_s) begin
        if (hdr_cnt_r == 1'b0) begin
          len_lo_r  <= bus.in_data;
          hdr_cnt_r <= 1'b1;
        end else begin
          len_r     <= len_full_s;
          hdr_cnt_r <= 1'b0;
        end
      end
      if (word_valid_s) begin
        index_r <= index_r + 16'd1;
      end
    end
  end

  // Registered outputs: IMEM write port, handshake and status lines.
  // cpu_reset lags DONE by one cycle so the last write lands before fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      imem_we_r    <= 1'b0;
      imem_addr_r  <= ADDR_BASE;
      imem_wdata_r <= 32'd0;
      in_ready_r   <= 1'b1;
      cpu_reset_r  <= 1'b1;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
    end else begin
      imem_we_r <= word_valid_s;
      if (word_valid_s) begin
        imem_addr_r  <= word_addr(ADDR_BASE, index_r);
        imem_wdata_r <= word_s;
      end
      in_ready_r  <= (next_state_s == ST_LEN) || (next_state_s == ST_DATA) ||
                     (next_state_s == ST_CHK);
      done_r      <= (next_state_s == ST_DONE);
      error_r     <= (next_state_s == ST_ERR);
      cpu_reset_r <= (state_r != ST_DONE);
    end
  end

  assign bus.in_ready   = in_ready_r;
  assign bus.imem_we    = imem_we_r;
  assign bus.imem_addr  = imem_addr_r;
  assign bus.imem_wdata = imem_wdata_r;
  assign bus.cpu_reset  = cpu_reset_r;
  assign bus.done       = done_r;
  assign bus.error      = error_r;

endmodule

// File: tb/tb_imem_loader.sv
// Cycle-by-cycle vector bench for imem_loader plus a stalled-stream
// sequence that collects IMEM writes. Tracks IMEM_LOADER_CHECKSUM_EN.
module tb_imem_loader;

  logic clk;
  logic reset;
  imem_loader_if bus();

  imem_loader #(.ADDR_BASE(32'h0000_0000), .MAX_WORDS(1024)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        vld;
    logic [7:0]  dat;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        rdy;
    logic        dn;
    logic        er;
    logic        cr;
  } vec_t;

  vec_t tbl[$];
  int   applied    = 0;
  int   miscompares = 0;

  task automatic v(input logic r, input logic vl, input logic [7:0] d,
                   input logic we, input logic [31:0] a, input logic [31:0] wd,
                   input logic rdy, input logic dn, input logic er, input logic cr);
    vec_t e;
    e.rst = r; e.vld = vl; e.dat = d; e.we = we; e.addr = a; e.wd = wd;
    e.rdy = rdy; e.dn = dn; e.er = er; e.cr = cr;
    tbl.push_back(e);
  endtask

  // Stream 02 00 13 00 00 00 93 00 10 00 from the post-reset state.
  task automatic full_stream();
    v(0, 1, 8'h02, 0, 32'h0, 32'h0,        1, 0, 0, 1);
    v(0, 1, 8'h00, 0, 32'h0, 32'h0,        1, 0, 0, 1);
    v(0, 1, 8'h13, 0, 32'h0, 32'h0,        1, 0, 0, 1);
    v(0, 1, 8'h00, 0, 32'h0, 32'h0,        1, 0, 0, 1);
    v(0, 1, 8'h00, 0, 32'h0, 32'h0,        1, 0, 0, 1);
    v(0, 1, 8'h00, 1, 32'h0, 32'h13,       1, 0, 0, 1);
    v(0, 1, 8'h93, 0, 32'h0, 32'h13,       1, 0, 0, 1);
    v(0, 1, 8'h00, 0, 32'h0, 32'h13,       1, 0, 0, 1);
    v(0, 1, 8'h10, 0, 32'h0, 32'h13,       1, 0, 0, 1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    v(0, 1, 8'h00, 1, 32'h4, 32'h0010_0093, 1, 0, 0, 1);
    v(0, 1, 8'h92, 0, 32'h4, 32'h0010_0093, 0, 1, 0, 1);
`else
    v(0, 1, 8'h00, 1, 32'h4, 32'h0010_0093, 0, 1, 0, 1);
`endif
    v(0, 0, 8'h00, 0, 32'h4, 32'h0010_0093, 0, 1, 0, 0);
    v(0, 1, 8'hAA, 0, 32'h4, 32'h0010_0093, 0, 1, 0, 0);
  endtask

  task automatic rst_vec();
    v(1, 1, 8'h02, 0, 32'h0, 32'h0, 1, 0, 0, 1);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    applied++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  logic [7:0]  stream [0:10];
  logic [31:0] w_addr [0:3];
  logic [31:0] w_data [0:3];
  int          n_bytes, idx, pulses, cyc;
  logic        did;

  initial begin
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    // Reset state; reset dominates a valid byte.
    v(1, 0, 8'h00, 0, 32'h0, 32'h0, 1, 0, 0, 1);
    rst_vec();

    // Back-to-back load.
    full_stream();

    // Same stream with in_valid low (garbage data) every other cycle.
    rst_vec();
    v(0, 0, 8'hFF, 0, 32'h0, 32'h0, 1, 0, 0, 1);
    v(0, 1, 8'h02, 0, 32'h0, 32'h0, 1, 0, 0, 1);
    v(0, 0, 8'hFF, 0, 32'h0, 32'h0, 1, 0, 0, 1);
    v(0, 1, 8'h00, 0, 32'h0, 32'h0, 1, 0, 0, 1);
    v(0, 0, 8'hFF, 0, 32'h0, 32'h0, 1, 0, 0, 1);
    v(0, 1, 8'h13, 0, 32'h0, 32'h0, 1, 0, 0, 1);
    v(0, 0, 8'hFF, 0, 32'h0, 32'h0, 1, 0, 0, 1);
    v(0, 1, 8'h00, 0, 32'h0, 32'h0, 1, 0, 0, 1);
    v(0, 0, 8'hFF, 0, 32'h0, 32'h0, 1, 0, 0, 1);
    v(0, 1, 8'h00, 0, 32'h0, 32'h0, 1, 0, 0, 1);
    v(0, 0, 8'hFF, 0, 32'h0, 32'h0, 1, 0, 0, 1);
    v(0, 1, 8'h00, 1, 32'h0, 32'h13, 1, 0, 0, 1);
    v(0, 0, 8'hFF, 0, 32'h0, 32'h13, 1, 0, 0, 1);
    v(0, 1, 8'h93, 0, 32'h0, 32'h13, 1, 0, 0, 1);
    v(0, 0, 8'hFF, 0, 32'h0, 32'h13, 1, 0, 0, 1);
    v(0, 1, 8'h00, 0, 32'h0, 32'h13, 1, 0, 0, 1);
    v(0, 0, 8'hFF, 0, 32'h0, 32'h13, 1, 0, 0, 1);
    v(0, 1, 8'h10, 0, 32'h0, 32'h13, 1, 0, 0, 1);
    v(0, 0, 8'hFF, 0, 32'h0, 32'h13, 1, 0, 0, 1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    v(0, 1, 8'h00, 1, 32'h4, 32'h0010_0093, 1, 0, 0, 1);
    v(0, 0, 8'hFF, 0, 32'h4, 32'h0010_0093, 1, 0, 0, 1);
    v(0, 1, 8'h92, 0, 32'h4, 32'h0010_0093, 0, 1, 0, 1);
`else
    v(0, 1, 8'h00, 1, 32'h4, 32'h0010_0093, 0, 1, 0, 1);
`endif
    v(0, 0, 8'hFF, 0, 32'h4, 32'h0010_0093, 0, 1, 0, 0);

    // Oversized header N=1025: error, no writes, CPU held, stream refused.
    rst_vec();
    v(0, 1, 8'h01, 0, 32'h0, 32'h0, 1, 0, 0, 1);
    v(0, 1, 8'h04, 0, 32'h0, 32'h0, 0, 0, 1, 1);
    v(0, 1, 8'h00, 0, 32'h0, 32'h0, 0, 0, 1, 1);
    v(0, 1, 8'h00, 0, 32'h0, 32'h0, 0, 0, 1, 1);

    // Empty image.
    rst_vec();
    v(0, 1, 8'h00, 0, 32'h0, 32'h0, 1, 0, 0, 1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    v(0, 1, 8'h00, 0, 32'h0, 32'h0, 1, 0, 0, 1);
`endif
    v(0, 1, 8'h00, 0, 32'h0, 32'h0, 0, 1, 0, 1);
    v(0, 0, 8'h00, 0, 32'h0, 32'h0, 0, 1, 0, 0);

    // Reset after 6 bytes, again after 8 (partial word pending), then reload.
    rst_vec();
    v(0, 1, 8'h02, 0, 32'h0, 32'h0,  1, 0, 0, 1);
    v(0, 1, 8'h00, 0, 32'h0, 32'h0,  1, 0, 0, 1);
    v(0, 1, 8'h13, 0, 32'h0, 32'h0,  1, 0, 0, 1);
    v(0, 1, 8'h00, 0, 32'h0, 32'h0,  1, 0, 0, 1);
    v(0, 1, 8'h00, 0, 32'h0, 32'h0,  1, 0, 0, 1);
    v(0, 1, 8'h00, 1, 32'h0, 32'h13, 1, 0, 0, 1);
    rst_vec();
    v(0, 1, 8'h02, 0, 32'h0, 32'h0,  1, 0, 0, 1);
    v(0, 1, 8'h00, 0, 32'h0, 32'h0,  1, 0, 0, 1);
    v(0, 1, 8'h13, 0, 32'h0, 32'h0,  1, 0, 0, 1);
    v(0, 1, 8'h00, 0, 32'h0, 32'h0,  1, 0, 0, 1);
    v(0, 1, 8'h00, 0, 32'h0, 32'h0,  1, 0, 0, 1);
    v(0, 1, 8'h00, 1, 32'h0, 32'h13, 1, 0, 0, 1);
    v(0, 1, 8'h93, 0, 32'h0, 32'h13, 1, 0, 0, 1);
    v(0, 1, 8'h00, 0, 32'h0, 32'h13, 1, 0, 0, 1);
    rst_vec();
    full_stream();

`ifdef IMEM_LOADER_CHECKSUM_EN
    // N=1, word DEADBEEF, good checksum 0x23.
    rst_vec();
    v(0, 1, 8'h01, 0, 32'h0, 32'h0, 1, 0, 0, 1);
    v(0, 1, 8'h00, 0, 32'h0, 32'h0, 1, 0, 0, 1);
    v(0, 1, 8'hEF, 0, 32'h0, 32'h0, 1, 0, 0, 1);
    v(0, 1, 8'hBE, 0, 32'h0, 32'h0, 1, 0, 0, 1);
    v(0, 1, 8'hAD, 0, 32'h0, 32'h0, 1, 0, 0, 1);
    v(0, 1, 8'hDE, 1, 32'h0, 32'hDEAD_BEEF, 1, 0, 0, 1);
    v(0, 1, 8'h23, 0, 32'h0, 32'hDEAD_BEEF, 0, 1, 0, 1);
    v(0, 0, 8'h00, 0, 32'h0, 32'hDEAD_BEEF, 0, 1, 0, 0);
    // Bad checksum 0x24: word still written, error, CPU held.
    rst_vec();
    v(0, 1, 8'h01, 0, 32'h0, 32'h0, 1, 0, 0, 1);
    v(0, 1, 8'h00, 0, 32'h0, 32'h0, 1, 0, 0, 1);
    v(0, 1, 8'hEF, 0, 32'h0, 32'h0, 1, 0, 0, 1);
    v(0, 1, 8'hBE, 0, 32'h0, 32'h0, 1, 0, 0, 1);
    v(0, 1, 8'hAD, 0, 32'h0, 32'h0, 1, 0, 0, 1);
    v(0, 1, 8'hDE, 1, 32'h0, 32'hDEAD_BEEF, 1, 0, 0, 1);
    v(0, 1, 8'h24, 0, 32'h0, 32'hDEAD_BEEF, 0, 0, 1, 1);
    v(0, 0, 8'h00, 0, 32'h0, 32'hDEAD_BEEF, 0, 0, 1, 1);
`endif

    // Apply the table: drive on the falling edge, check on the next one.
    foreach (tbl[i]) begin
      reset        = tbl[i].rst;
      bus.in_valid = tbl[i].vld;
      bus.in_data  = tbl[i].dat;
      @(negedge clk);
      applied++;
      if ({bus.imem_we, bus.imem_addr, bus.imem_wdata, bus.in_ready, bus.done,
           bus.error, bus.cpu_reset} !==
          {tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].rdy, tbl[i].dn,
           tbl[i].er, tbl[i].cr}) begin
        miscompares++;
        $display("FAIL vec%0d: got we=%b addr=%h wd=%h rdy=%b done=%b err=%b cpu_rst=%b want we=%b addr=%h wd=%h rdy=%b done=%b err=%b cpu_rst=%b",
                 i, bus.imem_we, bus.imem_addr, bus.imem_wdata, bus.in_ready,
                 bus.done, bus.error, bus.cpu_reset, tbl[i].we, tbl[i].addr,
                 tbl[i].wd, tbl[i].rdy, tbl[i].dn, tbl[i].er, tbl[i].cr);
      end
    end

    // Randomly stalled stream: collect every write strobe until done.
    stream[0] = 8'h02; stream[1] = 8'h00; stream[2] = 8'h13; stream[3] = 8'h00;
    stream[4] = 8'h00; stream[5] = 8'h00; stream[6] = 8'h93; stream[7] = 8'h00;
    stream[8] = 8'h10; stream[9] = 8'h00; stream[10] = 8'h92;
`ifdef IMEM_LOADER_CHECKSUM_EN
    n_bytes = 11;
`else
    n_bytes = 10;
`endif
    reset = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    idx = 0; pulses = 0; cyc = 0;
    while (!bus.done && cyc < 200) begin
      bus.in_valid = (idx < n_bytes) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.in_data  = (idx < n_bytes) ? stream[idx] : 8'hFF;
      did = bus.in_valid && bus.in_ready;
      @(negedge clk);
      if (did) idx++;
      if (bus.imem_we) begin
        if (pulses < 4) begin
          w_addr[pulses] = bus.imem_addr;
          w_data[pulses] = bus.imem_wdata;
        end
        pulses++;
      end
      cyc++;
    end
    bus.in_valid = 1'b0;
    check("stall_done", 32'(bus.done), 32'd1);
    check("stall_pulses", 32'(pulses), 32'd2);
    if (pulses >= 2) begin
      check("stall_a0", w_addr[0], 32'h0);
      check("stall_d0", w_data[0], 32'h0000_0013);
      check("stall_a1", w_addr[1], 32'h4);
      check("stall_d1", w_data[1], 32'h0010_0093);
    end
    check("stall_cpu_rst_held", 32'(bus.cpu_reset), 32'd1);
    @(negedge clk);
    check("stall_cpu_rst_rel", 32'(bus.cpu_reset), 32'd0);
    check("stall_no_extra_we", 32'(bus.imem_we), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
